// File: rtl/vga_pkg.sv
// Shared VGA types: display modes, timing parameter record, mode-switch sequencer states
// and the mode-to-timing lookup used by the timing generator and the mode controller.
package vga_pkg;

    typedef enum logic [3:0] {
        VGA_640x480_60   = 4'd0,
        VGA_800x600_60   = 4'd1,
        VGA_1024x768_60  = 4'd2,
        VGA_1280x720_60  = 4'd3,
        VGA_1920x1080_60 = 4'd4
    } vga_mode_e;

    typedef struct packed {
        logic [11:0] visible_area;
        logic [9:0]  front_porch;
        logic [9:0]  sync_pulse;
        logic [9:0]  back_porch;
        logic        polarity;
    } vga_line_t;

    // 4 + 43 + 43 = 90 bits, the width of the timing generator's parameter bus
    typedef struct packed {
        vga_mode_e mode;
        vga_line_t h_line;
        vga_line_t v_line;
    } vga_params_t;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_FRAME = 3'd1,
        ST_PLL_REQ    = 3'd2,
        ST_PLL_LOCK   = 3'd3,
        ST_LOAD       = 3'd4,
        ST_SETTLE     = 3'd5,
        ST_ERROR      = 3'd6
    } vga_ctrl_state_e;

    function automatic vga_line_t make_vga_line(
        input int unsigned visible,
        input int unsigned front,
        input int unsigned pulse,
        input int unsigned back,
        input logic        pol
    );
        vga_line_t l;
        l.visible_area = 12'(visible);
        l.front_porch  = 10'(front);
        l.sync_pulse   = 10'(pulse);
        l.back_porch   = 10'(back);
        l.polarity     = pol;
        return l;
    endfunction

    // Unknown codes fall back to 640x480 so the generator never gets an unusable record
    function automatic vga_params_t get_vga_params(input vga_mode_e mode);
        vga_params_t p;
        p.mode = mode;
        case (mode)
            VGA_800x600_60: begin
                p.h_line = make_vga_line(800, 40, 128, 88, 1'b1);
                p.v_line = make_vga_line(600, 1, 4, 23, 1'b1);
            end
            VGA_1024x768_60: begin
                p.h_line = make_vga_line(1024, 24, 136, 160, 1'b0);
                p.v_line = make_vga_line(768, 3, 6, 29, 1'b0);
            end
            VGA_1280x720_60: begin
                p.h_line = make_vga_line(1280, 110, 40, 220, 1'b1);
                p.v_line = make_vga_line(720, 5, 5, 20, 1'b1);
            end
            VGA_1920x1080_60: begin
                p.h_line = make_vga_line(1920, 88, 44, 148, 1'b1);
                p.v_line = make_vga_line(1080, 4, 5, 36, 1'b1);
            end
            default: begin
                p.mode   = VGA_640x480_60;
                p.h_line = make_vga_line(640, 16, 96, 48, 1'b0);
                p.v_line = make_vga_line(480, 10, 2, 33, 1'b0);
            end
        endcase
        return p;
    endfunction

endpackage

// File: rtl/vga_mode_ctrl_sync.sv
// Two-flop synchronizer bringing the asynchronous PLL lock indication into the system
// clock domain; clears to 0 on reset.
module vga_mode_ctrl_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic async_i,
    output logic sync_o
);

    logic [1:0] sync_reg;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_reg <= 2'b00;
        end else begin
            sync_reg <= {sync_reg[0], async_i};
        end
    end

    assign sync_o = sync_reg[1];

endmodule

// File: rtl/vga_mode_ctrl.sv
// Run-time VGA mode-switch sequencer: frame-aligned blanking, optional PLL reprogramming,
// timing load and settle. PLL handshake is compiled in only with VGA_MODE_CTRL_PLL_EN.
module vga_mode_ctrl
    import vga_pkg::*;
#(
    parameter vga_mode_e   DEFAULT_MODE  = VGA_640x480_60,
    parameter int unsigned LOCK_TIMEOUT  = 1_000_000,
    parameter int unsigned SETTLE_FRAMES = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        mode_req_valid_i,
    output logic        mode_req_ready_o,
    input  logic [3:0]  mode_req_i,
    input  logic        frame_end_i,
    output logic        pll_reconf_req_o,
    output logic [3:0]  pll_reconf_mode_o,
    input  logic        pll_reconf_ack_i,
    input  logic        pll_locked_i,
    output logic [89:0] timing_params_o,
    output logic        timing_load_o,
    output logic        timing_en_o,
    output logic        video_blank_o,
    output logic [3:0]  cur_mode_o,
    output logic        busy_o,
    output logic        err_o
);

    localparam vga_params_t DEFAULT_PARAMS = get_vga_params(DEFAULT_MODE);
    localparam int SETTLE_W = (SETTLE_FRAMES > 1) ? $clog2(SETTLE_FRAMES) : 1;
    localparam logic [SETTLE_W-1:0] SETTLE_LAST =
        SETTLE_W'((SETTLE_FRAMES > 0) ? SETTLE_FRAMES - 1 : 0);

`ifdef VGA_MODE_CTRL_PLL_EN
    localparam vga_ctrl_state_e RESET_STATE = ST_PLL_LOCK;
    localparam int LOCK_W = $clog2(LOCK_TIMEOUT + 1);
    localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_TIMEOUT - 1);
    localparam logic [LOCK_W-1:0] LOCK_MAX  = LOCK_W'(LOCK_TIMEOUT);
`else
    localparam vga_ctrl_state_e RESET_STATE = ST_LOAD;
    localparam int unsigned UNUSED_LOCK_TIMEOUT = LOCK_TIMEOUT;
`endif

    vga_ctrl_state_e       state_reg;
    vga_mode_e             tgt_mode_reg;
    vga_mode_e             cur_mode_reg;
    vga_params_t           params_reg;
    logic                  ready_reg;
    logic                  load_reg;
    logic                  en_reg;
    logic                  blank_reg;
    logic                  busy_reg;
    logic [SETTLE_W-1:0]   settle_cnt_reg;

    logic      req_accept;
    vga_mode_e req_mode;

    assign req_accept = mode_req_valid_i & ready_reg;
    assign req_mode   = vga_mode_e'(mode_req_i);

`ifdef VGA_MODE_CTRL_PLL_EN
    logic              locked_sync;
    logic              pll_req_reg;
    vga_mode_e         pll_mode_reg;
    logic              err_reg;
    logic [LOCK_W-1:0] lock_cnt_reg;
    logic              need_low_reg;

    vga_mode_ctrl_sync u_lock_sync (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .async_i (pll_locked_i),
        .sync_o  (locked_sync)
    );
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg      <= RESET_STATE;
            tgt_mode_reg   <= DEFAULT_MODE;
            cur_mode_reg   <= DEFAULT_MODE;
            params_reg     <= DEFAULT_PARAMS;
            ready_reg      <= 1'b0;
            load_reg       <= 1'b0;
            en_reg         <= 1'b0;
            blank_reg      <= 1'b1;
            busy_reg       <= 1'b1;
            settle_cnt_reg <= '0;
`ifdef VGA_MODE_CTRL_PLL_EN
            pll_req_reg    <= 1'b0;
            pll_mode_reg   <= DEFAULT_MODE;
            err_reg        <= 1'b0;
            lock_cnt_reg   <= '0;
            need_low_reg   <= 1'b0;
`endif
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (req_accept && (req_mode != cur_mode_reg)) begin
                        tgt_mode_reg <= req_mode;
                        ready_reg    <= 1'b0;
                        busy_reg     <= 1'b1;
                        state_reg    <= ST_WAIT_FRAME;
                    end
                end

                ST_WAIT_FRAME: begin
                    if (frame_end_i) begin
                        blank_reg <= 1'b1;
                        en_reg    <= 1'b0;
`ifdef VGA_MODE_CTRL_PLL_EN
                        pll_req_reg  <= 1'b1;
                        pll_mode_reg <= tgt_mode_reg;
                        state_reg    <= ST_PLL_REQ;
`else
                        load_reg     <= 1'b1;
                        params_reg   <= get_vga_params(tgt_mode_reg);
                        cur_mode_reg <= tgt_mode_reg;
                        state_reg    <= ST_LOAD;
`endif
                    end
                end

`ifdef VGA_MODE_CTRL_PLL_EN
                ST_PLL_REQ: begin
                    if (pll_reconf_ack_i) begin
                        pll_req_reg  <= 1'b0;
                        lock_cnt_reg <= '0;
                        need_low_reg <= 1'b1;
                        state_reg    <= ST_PLL_LOCK;
                    end
                end

                // A reconfigured PLL must be seen unlocked before its lock is trusted
                ST_PLL_LOCK: begin
                    if (!need_low_reg && locked_sync) begin
                        load_reg     <= 1'b1;
                        params_reg   <= get_vga_params(tgt_mode_reg);
                        cur_mode_reg <= tgt_mode_reg;
                        state_reg    <= ST_LOAD;
                    end else if (lock_cnt_reg == LOCK_LAST) begin
                        err_reg   <= 1'b1;
                        en_reg    <= 1'b0;
                        blank_reg <= 1'b1;
                        ready_reg <= 1'b1;
                        busy_reg  <= 1'b0;
                        state_reg <= ST_ERROR;
                    end else begin
                        if (!locked_sync) begin
                            need_low_reg <= 1'b0;
                        end
                        if (lock_cnt_reg != LOCK_MAX) begin
                            lock_cnt_reg <= lock_cnt_reg + 1'b1;
                        end
                    end
                end

                // Timing is stopped here, so a new mode goes straight to the PLL
                ST_ERROR: begin
                    if (req_accept) begin
                        err_reg      <= 1'b0;
                        tgt_mode_reg <= req_mode;
                        pll_mode_reg <= req_mode;
                        pll_req_reg  <= 1'b1;
                        ready_reg    <= 1'b0;
                        busy_reg     <= 1'b1;
                        state_reg    <= ST_PLL_REQ;
                    end
                end
`endif

                // Entry normally arrives with the strobe already raised; straight out of
                // reset it is raised here first so the generator still sees one load.
                ST_LOAD: begin
                    if (!load_reg) begin
                        load_reg     <= 1'b1;
                        params_reg   <= get_vga_params(tgt_mode_reg);
                        cur_mode_reg <= tgt_mode_reg;
                    end else begin
                        load_reg       <= 1'b0;
                        en_reg         <= 1'b1;
                        settle_cnt_reg <= '0;
                        if (SETTLE_FRAMES == 0) begin
                            blank_reg <= 1'b0;
                            ready_reg <= 1'b1;
                            busy_reg  <= 1'b0;
                            state_reg <= ST_IDLE;
                        end else begin
                            state_reg <= ST_SETTLE;
                        end
                    end
                end

                ST_SETTLE: begin
                    if (frame_end_i) begin
                        if (settle_cnt_reg == SETTLE_LAST) begin
                            blank_reg <= 1'b0;
                            ready_reg <= 1'b1;
                            busy_reg  <= 1'b0;
                            state_reg <= ST_IDLE;
                        end else begin
                            settle_cnt_reg <= settle_cnt_reg + 1'b1;
                        end
                    end
                end

                default: begin
                    state_reg <= RESET_STATE;
                end
            endcase
        end
    end

    assign mode_req_ready_o = ready_reg;
    assign timing_params_o  = params_reg;
    assign timing_load_o    = load_reg;
    assign timing_en_o      = en_reg;
    assign video_blank_o    = blank_reg;
    assign cur_mode_o       = cur_mode_reg;
    assign busy_o           = busy_reg;

`ifdef VGA_MODE_CTRL_PLL_EN
    assign pll_reconf_req_o  = pll_req_reg;
    assign pll_reconf_mode_o = pll_mode_reg;
    assign err_o             = err_reg;
`else
    logic unused_pll_inputs;
    assign unused_pll_inputs = pll_reconf_ack_i ^ pll_locked_i;
    assign pll_reconf_req_o  = 1'b0;
    assign pll_reconf_mode_o = cur_mode_reg;
    assign err_o             = 1'b0;
`endif

endmodule

// File: tb/tb_vga_mode_ctrl.sv
// Self-checking bench for vga_mode_ctrl against a table-driven mode/timing model; covers
// both builds, with or without VGA_MODE_CTRL_PLL_EN.
module tb_vga_mode_ctrl;
    import vga_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        valid = 1'b0;
    logic        ready;
    logic [3:0]  mode_req = 4'd0;
    logic        frame = 1'b0;
    logic        pll_req;
    logic [3:0]  pll_mode;
    logic        ack = 1'b0;
    logic        locked = 1'b0;
    logic [89:0] params;
    logic        load;
    logic        en;
    logic        blank;
    logic [3:0]  cur_mode;
    logic        busy;
    logic        err;

    int errors = 0;
    int checks = 0;
    int model_mode = 0;
    int txn = 0;

    // Published timings: visible, front porch, sync, back porch, polarity per axis
    int h_vis[5] = '{640, 800, 1024, 1280, 1920};
    int h_fp [5] = '{16, 40, 24, 110, 88};
    int h_sp [5] = '{96, 128, 136, 40, 44};
    int h_bp [5] = '{48, 88, 160, 220, 148};
    int h_pol[5] = '{0, 1, 0, 1, 1};
    int v_vis[5] = '{480, 600, 768, 720, 1080};
    int v_fp [5] = '{10, 1, 3, 5, 4};
    int v_sp [5] = '{2, 4, 6, 5, 5};
    int v_bp [5] = '{33, 23, 29, 20, 36};
    int v_pol[5] = '{0, 1, 0, 1, 1};

    always #5 clk = ~clk;

    vga_mode_ctrl #(
        .DEFAULT_MODE  (VGA_640x480_60),
        .LOCK_TIMEOUT  (100),
        .SETTLE_FRAMES (2)
    ) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .mode_req_valid_i  (valid),
        .mode_req_ready_o  (ready),
        .mode_req_i        (mode_req),
        .frame_end_i       (frame),
        .pll_reconf_req_o  (pll_req),
        .pll_reconf_mode_o (pll_mode),
        .pll_reconf_ack_i  (ack),
        .pll_locked_i      (locked),
        .timing_params_o   (params),
        .timing_load_o     (load),
        .timing_en_o       (en),
        .video_blank_o     (blank),
        .cur_mode_o        (cur_mode),
        .busy_o            (busy),
        .err_o             (err)
    );

    function automatic vga_params_t ref_params(input int m);
        vga_params_t p;
        p.mode                = vga_mode_e'(4'(m));
        p.h_line.visible_area = 12'(h_vis[m]);
        p.h_line.front_porch  = 10'(h_fp[m]);
        p.h_line.sync_pulse   = 10'(h_sp[m]);
        p.h_line.back_porch   = 10'(h_bp[m]);
        p.h_line.polarity     = h_pol[m] != 0;
        p.v_line.visible_area = 12'(v_vis[m]);
        p.v_line.front_porch  = 10'(v_fp[m]);
        p.v_line.sync_pulse   = 10'(v_sp[m]);
        p.v_line.back_porch   = 10'(v_bp[m]);
        p.v_line.polarity     = v_pol[m] != 0;
        return p;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_frame();
        frame = 1'b1;
        tick();
        frame = 1'b0;
    endtask

    task automatic test_reset();
        int found;
        vga_params_t p;
        rst = 1'b1; valid = 1'b0; frame = 1'b0; ack = 1'b0; locked = 1'b0;
        repeat (5) tick();
        checks++;
        if ({ready, pll_req, load, en, err, blank, busy} !== 7'b0000011) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 0000011 (rdy,req,load,en,err,blank,busy)",
                     {ready, pll_req, load, en, err, blank, busy});
        end
        checks++;
        if ({cur_mode, pll_mode} !== 8'h00 || params !== ref_params(0)) begin
            errors++;
            $display("FAIL reset_mode: got cur=%0d pll=%0d params=%h expected 0 0 %h",
                     cur_mode, pll_mode, params, ref_params(0));
        end
        rst = 1'b0;
        locked = 1'b1;
        found = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (load === 1'b1) begin
                found = 1;
                break;
            end
        end
        checks++;
        if (found == 0) begin
            errors++;
            $display("FAIL bringup_load: got no load strobe within 20 cycles, expected one");
        end
        p = params;
        checks++;
        if (cur_mode !== 4'd0 || p.h_line.visible_area !== 12'd640) begin
            errors++;
            $display("FAIL bringup_params: got cur=%0d visible=%0d expected 0 640",
                     cur_mode, p.h_line.visible_area);
        end
        tick();
        checks++;
        if ({load, en, blank} !== 3'b011) begin
            errors++;
            $display("FAIL bringup_enable: got load,en,blank=%b expected 011", {load, en, blank});
        end
        pulse_frame();
        checks++;
        if (blank !== 1'b1) begin
            errors++;
            $display("FAIL bringup_settle1: got blank=%b expected 1", blank);
        end
        pulse_frame();
        checks++;
        if ({blank, busy, ready} !== 3'b001) begin
            errors++;
            $display("FAIL bringup_settle2: got blank,busy,ready=%b expected 001", {blank, busy, ready});
        end
        model_mode = 0;
        $display("txn bringup: mode 0 live");
    endtask

    // From load strobe through both settle frames back to idle
    task automatic finish_load(input int m);
        checks++;
        if ({load, cur_mode, pll_mode} !== {1'b1, 4'(m), 4'(m)} || params !== ref_params(m)) begin
            errors++;
            $display("FAIL load_m%0d: got load=%b cur=%0d pll=%0d params=%h expected 1 %0d %0d %h",
                     m, load, cur_mode, pll_mode, params, m, m, ref_params(m));
        end
        tick();
        checks++;
        if ({load, en, blank, busy} !== 4'b0111) begin
            errors++;
            $display("FAIL post_load: got load,en,blank,busy=%b expected 0111", {load, en, blank, busy});
        end
        for (int f = 0; f < 2; f++) begin
            repeat ($urandom_range(0, 3)) tick();
            pulse_frame();
            checks++;
            if (blank !== ((f == 0) ? 1'b1 : 1'b0)) begin
                errors++;
                $display("FAIL settle_f%0d: got blank=%b expected %0d", f, blank, (f == 0) ? 1 : 0);
            end
        end
        checks++;
        if ({busy, ready, en} !== 3'b011) begin
            errors++;
            $display("FAIL back_idle: got busy,ready,en=%b expected 011", {busy, ready, en});
        end
        model_mode = m;
    endtask

`ifdef VGA_MODE_CTRL_PLL_EN
    task automatic pll_handshake(input int m, input int ack_delay);
        checks++;
        if ({pll_req, pll_mode, blank, en} !== {1'b1, 4'(m), 2'b10}) begin
            errors++;
            $display("FAIL pll_req_m%0d: got req=%b mode=%0d blank=%b en=%b expected 1 %0d 1 0",
                     m, pll_req, pll_mode, blank, en, m);
        end
        repeat (ack_delay) tick();
        checks++;
        if (pll_req !== 1'b1) begin
            errors++;
            $display("FAIL pll_req_hold: got req=%b expected 1", pll_req);
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        checks++;
        if (pll_req !== 1'b0) begin
            errors++;
            $display("FAIL pll_req_drop: got req=%b expected 0", pll_req);
        end
        locked = 1'b0;
        repeat (4) tick();
        locked = 1'b1;
        tick();
        tick();
        checks++;
        if (load !== 1'b0) begin
            errors++;
            $display("FAIL lock_latency_early: got load=%b expected 0", load);
        end
        tick();
    endtask
`endif

    task automatic do_change(input int m);
        int other;
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL req_ready: got ready=%b expected 1", ready);
        end
        valid = 1'b1;
        mode_req = 4'(m);
        frame = 1'($urandom_range(0, 1));
        tick();
        valid = 1'b0;
        frame = 1'b0;
        txn++;
        $display("txn %0d: request mode %0d from mode %0d", txn, m, model_mode);
        if (m == model_mode) begin
            for (int i = 0; i < 4; i++) begin
                frame = 1'(i & 1);
                tick();
                checks++;
                if ({load, pll_req, busy, ready} !== 4'b0001) begin
                    errors++;
                    $display("FAIL same_mode: got load,req,busy,ready=%b expected 0001",
                             {load, pll_req, busy, ready});
                end
            end
            frame = 1'b0;
            return;
        end
        checks++;
        if ({ready, busy, blank} !== 3'b010) begin
            errors++;
            $display("FAIL accept: got ready,busy,blank=%b expected 010", {ready, busy, blank});
        end
        other = (m + 1) % 5;
        valid = 1'b1;
        mode_req = 4'(other);
        tick();
        valid = 1'b0;
        repeat ($urandom_range(0, 4)) tick();
        checks++;
        if ({load, pll_req, blank} !== 3'b000) begin
            errors++;
            $display("FAIL wait_frame: got load,req,blank=%b expected 000", {load, pll_req, blank});
        end
        pulse_frame();
`ifdef VGA_MODE_CTRL_PLL_EN
        pll_handshake(m, $urandom_range(0, 5));
`else
        checks++;
        if ({pll_req, blank, en} !== 3'b010) begin
            errors++;
            $display("FAIL frame_blank: got req,blank,en=%b expected 010", {pll_req, blank, en});
        end
`endif
        finish_load(m);
    endtask

    task automatic test_mode_800();
        vga_params_t p;
        do_change(1);
        p = params;
        checks++;
        if ({p.h_line.sync_pulse, p.h_line.polarity, blank} !== {10'd128, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL mode_800: got sync=%0d pol=%b blank=%b expected 128 1 0",
                     p.h_line.sync_pulse, p.h_line.polarity, blank);
        end
    endtask

    task automatic test_same_mode();
        do_change(model_mode);
    endtask

    task automatic test_random_changes(input int n);
        for (int t = 0; t < n; t++) begin
            repeat ($urandom_range(0, 3)) tick();
            do_change(int'($urandom_range(0, 4)));
        end
    endtask

    task automatic test_1080_load();
        vga_params_t p;
        if (model_mode == 4) do_change(0);
        do_change(4);
        p = params;
        checks++;
        if (p.h_line.visible_area !== 12'd1920 || pll_req !== 1'b0) begin
            errors++;
            $display("FAIL mode_1080: got visible=%0d req=%b expected 1920 0",
                     p.h_line.visible_area, pll_req);
        end
    endtask

`ifdef VGA_MODE_CTRL_PLL_EN
    task automatic test_lock_timeout();
        int m;
        m = (model_mode + 1) % 5;
        valid = 1'b1;
        mode_req = 4'(m);
        tick();
        valid = 1'b0;
        pulse_frame();
        ack = 1'b1;
        tick();
        ack = 1'b0;
        locked = 1'b0;
        repeat (99) tick();
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_early: got err=%b expected 0", err);
        end
        tick();
        checks++;
        if ({err, ready, busy, blank, en} !== 5'b11010) begin
            errors++;
            $display("FAIL timeout: got err,ready,busy,blank,en=%b expected 11010",
                     {err, ready, busy, blank, en});
        end
        txn++;
        $display("txn %0d: lock timeout, retry with mode 3", txn);
        valid = 1'b1;
        mode_req = 4'd3;
        tick();
        valid = 1'b0;
        checks++;
        if ({err, pll_req, pll_mode, busy} !== {2'b01, 4'd3, 1'b1}) begin
            errors++;
            $display("FAIL error_retry: got err=%b req=%b mode=%0d busy=%b expected 0 1 3 1",
                     err, pll_req, pll_mode, busy);
        end
        pll_handshake(3, 4);
        finish_load(3);
    endtask
`endif

    task automatic test_reset_mid();
        int m;
        m = (model_mode + 2) % 5;
        valid = 1'b1;
        mode_req = 4'(m);
        tick();
        valid = 1'b0;
        pulse_frame();
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({pll_req, load, en, blank, busy, ready, err} !== 7'b0001100 || cur_mode !== 4'd0) begin
            errors++;
            $display("FAIL reset_mid: got req,load,en,blank,busy,ready,err=%b cur=%0d expected 0001100 0",
                     {pll_req, load, en, blank, busy, ready, err}, cur_mode);
        end
        txn++;
        $display("txn %0d: reset mid-sequence toward mode %0d", txn, m);
        test_reset();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_mode_800();
        test_same_mode();
        test_random_changes(12);
        test_1080_load();
`ifdef VGA_MODE_CTRL_PLL_EN
        test_lock_timeout();
`endif
        test_reset_mid();
        test_random_changes(4);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vga_mode_ctrl.md
# vga_mode_ctrl

Run-time VGA mode-switch sequencer. It sits between a host request port and the VGA timing generator, and, when compiled in, the pixel-clock PLL reconfiguration port. For each accepted mode change it waits for a frame boundary, blanks video, reprograms the PLL, loads the new `vga_params_t` into the timing generator and lets it settle before unblanking. It runs on a free-running system clock, not the pixel clock.

## Interface
- `DEFAULT_MODE`, `VGA_640x480_60`: mode brought up after reset.
- `LOCK_TIMEOUT`, 1_000_000: maximum number of `clk_i` cycles to wait for PLL lock.
- `SETTLE_FRAMES`, 2: number of `frame_end_i` pulses kept blanked after a load. 0 is legal.

Ports:
- `clk_i`, in, 1: system clock, free-running.
- `rst_i`, in, 1: asynchronous, active-high reset.
- `mode_req_valid_i`, in, 1: mode change request valid.
- `mode_req_ready_o`, out, 1: request can be accepted.
- `mode_req_i`, in, 4: requested `vga_mode_e`.
- `frame_end_i`, in, 1: one-cycle pulse at the last pixel of a frame. The caller synchronizes it to `clk_i`.
- `pll_reconf_req_o`, out, 1: PLL reconfiguration request.
- `pll_reconf_mode_o`, out, 4: target mode for the PLL.
- `pll_reconf_ack_i`, in, 1: PLL reconfiguration accepted.
- `pll_locked_i`, in, 1: PLL lock. Asynchronous; synchronized internally with 2 flops.
- `timing_params_o`, out, 90: `vga_params_t` for the timing generator.
- `timing_load_o`, out, 1: one-cycle strobe; the generator samples `timing_params_o` on it.
- `timing_en_o`, out, 1: timing generator run enable.
- `video_blank_o`, out, 1: force the pixel output to `BLACK`.
- `cur_mode_o`, out, 4: mode currently in effect.
- `busy_o`, out, 1: high in every state except IDLE and ERROR.
- `err_o`, out, 1: sticky lock-timeout flag.

## Operation
- **Reset values:**
  - `mode_req_ready_o`=0, `pll_reconf_req_o`=0, `timing_load_o`=0, `timing_en_o`=0, `err_o`=0.
  - `video_blank_o`=1, `busy_o`=1.
  - `cur_mode_o`=`DEFAULT_MODE`, `pll_reconf_mode_o`=`DEFAULT_MODE`, `timing_params_o`=`get_vga_params(DEFAULT_MODE)`.
  - State after reset: PLL_LOCK (or LOAD without PLL support).
- **States:** IDLE, WAIT_FRAME, PLL_REQ, PLL_LOCK, LOAD, SETTLE, ERROR.
- **IDLE:** `mode_req_ready_o`=1. On valid&ready, latch `mode_req_i` into `tgt_mode`.
  - If `tgt_mode`==`cur_mode_o`: no action, stay in IDLE.
  - Otherwise go to WAIT_FRAME.
- **WAIT_FRAME:** wait for `frame_end_i`.
  - A pulse in the same cycle the request is accepted does not count.
  - On the pulse: `video_blank_o`←1, `timing_en_o`←0, then go to PLL_REQ.
- **PLL_REQ:** `pll_reconf_req_o`=1 and `pll_reconf_mode_o`=`tgt_mode`, held until `pll_reconf_ack_i` is sampled high.
  - The request drops on the following cycle.
  - Then go to PLL_LOCK and clear the timeout counter.
- **PLL_LOCK:**
  - First wait until synced lock is seen low (the PLL drops lock after reconfig). This wait is skipped after reset.
  - Then wait until synced lock is high, and go to LOAD.
  - If the counter reaches `LOCK_TIMEOUT`: `err_o`←1, go to ERROR.
- **LOAD:** exactly one cycle.
  - `timing_params_o`←`get_vga_params(tgt_mode)`, `cur_mode_o`←`tgt_mode`, `timing_load_o`=1.
  - `timing_en_o`←1 on the next cycle, then go to SETTLE.
- **SETTLE:** count `SETTLE_FRAMES` pulses of `frame_end_i`, then `video_blank_o`←0 and go to IDLE. With `SETTLE_FRAMES`=0, go straight to IDLE.
- **ERROR:** `timing_en_o`=0, `video_blank_o`=1, `mode_req_ready_o`=1.
  - An accepted request clears `err_o`, latches `tgt_mode` and goes directly to PLL_REQ (no frame wait, because timing is disabled).
  - A request equal to `cur_mode_o` is not ignored here.

## Timing
- Valid/ready handshake. `mode_req_valid_i` may drop without acceptance. Acceptance is the cycle where valid&ready are both high, and `mode_req_ready_o` deasserts on the next cycle.
- `pll_reconf_ack_i` is ignored outside PLL_REQ. `frame_end_i` is ignored outside WAIT_FRAME and SETTLE.
- Locked-to-LOAD latency is 3 cycles: 2 cycles of synchronizer plus 1 cycle of transition.
- The timeout counter is `$clog2(LOCK_TIMEOUT+1)` bits wide and saturates.
- `rst_i` asserted mid-sequence returns all outputs to their reset values immediately (asynchronously), including dropping `pll_reconf_req_o`.

## Configuration
- `VGA_MODE_CTRL_PLL_EN` defined: full sequence as described above.
- Not defined: PLL_REQ, PLL_LOCK and ERROR are removed.
  - WAIT_FRAME goes directly to LOAD.
  - `pll_reconf_req_o`=0 constantly, `pll_reconf_mode_o`=`cur_mode_o`, `err_o`=0 constantly.
  - After reset the block starts in LOAD.

## Structure
- `vga_pkg` gains `vga_ctrl_state_e` (3-bit enum of the states above).
- It reuses the existing `vga_mode_e`, `vga_params_t` and `get_vga_params`.
- Sub-module `vga_mode_ctrl_sync`: a 2-flop synchronizer for `pll_locked_i`, with asynchronous reset to 0.

## Test plan
- **Reset bring-up:** `rst_i` high for 5 cycles, then lock rises → `timing_load_o` pulses, `cur_mode_o`=`VGA_640x480_60`, `timing_params_o.h_line.visible_area`=640; `video_blank_o` falls after 2 `frame_end_i` pulses.
- **Mode change to `VGA_800x600_60`:** request → nothing happens until `frame_end_i`; then PLL request with mode=1 and ack after 4 cycles; lock falls then rises → `h_line.sync_pulse`=128, `polarity`=1, `video_blank_o`=0 after 2 frames.
- **Same-mode request:** no PLL request, no load, `busy_o` stays 0.
- **Lock timeout** (`LOCK_TIMEOUT`=100, lock held low) → `err_o`=1 at cycle 100; a new request for `VGA_1280x720_60` → `err_o` cleared and PLL request issued without waiting for `frame_end_i`.
- **Reset during PLL_REQ** → `pll_reconf_req_o`=0 within the same cycle, `video_blank_o`=1.
- **Built without `VGA_MODE_CTRL_PLL_EN`:** request for `VGA_1920x1080_60` → load occurs 1 cycle after `frame_end_i`, `h_line.visible_area`=1920, `pll_reconf_req_o` never asserts.
